// File: rtl/alu_scheduler.sv
// alu_scheduler: arbitrates two command requesters onto one shared combinational ALU.
// One command is in flight at a time. Round-robin arbitration picks between requesters.
// A MUL command runs a 16-cycle shift-add loop through the same ALU.
//
// Ports:
//   clock, reset                 single clock; async active-high reset
//   req{0,1}_valid/op/x/y        command from requester 0/1
//   req{0,1}_ready               command accepted when valid & ready
//   alu_x, alu_y, alu_zx..alu_no operands and control bits to the shared ALU
//   alu_out, alu_zr, alu_ng      combinational ALU results, returned in the same cycle
//   resp_valid/id/data/zr/ng     response to the consumer, held until resp_ready
//   resp_ready                   consumer accepts the response
module alu_scheduler (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [2:0]  req0_op,
   input  logic [15:0] req0_x,
   input  logic [15:0] req0_y,
   input  logic        req1_valid,
   input  logic [2:0]  req1_op,
   input  logic [15:0] req1_x,
   input  logic [15:0] req1_y,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic        alu_zx,
   output logic        alu_nx,
   output logic        alu_zy,
   output logic        alu_ny,
   output logic        alu_f,
   output logic        alu_no,
   input  logic [15:0] alu_out,
   input  logic        alu_zr,
   input  logic        alu_ng,
   output logic        resp_valid,
   output logic        resp_id,
   output logic [15:0] resp_data,
   output logic        resp_zr,
   output logic        resp_ng,
   input  logic        resp_ready
);

   typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

   localparam logic [2:0] OpMul   = 3'd5;
   localparam logic [5:0] CtrlAdd = 6'b000010;

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   // During MUL, x_q/y_q double as the shifting multiplicand/multiplier.
   logic [15:0] x_q, x_d, y_q, y_d;
   logic [15:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        id_q, id_d;
   logic        last_q, last_d;
   logic [15:0] rdata_q, rdata_d;
   logic        rzr_q, rzr_d, rng_q, rng_d;

   logic        grant_id;
   logic [2:0]  sel_op;
   logic [5:0]  op_ctrl, ctrl;
   logic [15:0] mul_sum;

   // Contention goes to the requester not granted last.
   assign grant_id = (req0_valid & req1_valid) ? ~last_q : req1_valid;
   assign sel_op   = grant_id ? req1_op : req0_op;

   always_comb begin
      op_ctrl = 6'b000000;
      unique case (op_q)
         3'd0:    op_ctrl = 6'b000010;
         3'd1:    op_ctrl = 6'b010011;
         3'd2:    op_ctrl = 6'b000000;
         3'd3:    op_ctrl = 6'b010101;
         3'd4:    op_ctrl = 6'b001111;
         default: op_ctrl = 6'b000000;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      x_d        = x_q;
      y_d        = y_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      id_d       = id_q;
      last_d     = last_q;
      rdata_d    = rdata_q;
      rzr_d      = rzr_q;
      rng_d      = rng_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      alu_x      = 16'h0000;
      alu_y      = 16'h0000;
      ctrl       = 6'b000000;
      mul_sum    = 16'h0000;
      unique case (state_q)
         StIdle: begin
            req0_ready = ~reset & req0_valid & ~grant_id;
            req1_ready = ~reset & req1_valid & grant_id;
            if (req0_valid | req1_valid) begin
               op_d    = sel_op;
               x_d     = grant_id ? req1_x : req0_x;
               y_d     = grant_id ? req1_y : req0_y;
               id_d    = grant_id;
               last_d  = grant_id;
               acc_d   = 16'h0000;
               cnt_d   = 4'd0;
               state_d = (sel_op == OpMul) ? StMul : StExec;
            end
         end
         StExec: begin
            if (op_q[2] & op_q[1]) begin
               // Reserved ops bypass the ALU with a fixed zero result.
               rdata_d = 16'h0000;
               rzr_d   = 1'b1;
               rng_d   = 1'b0;
            end else begin
               alu_x   = x_q;
               alu_y   = y_q;
               ctrl    = op_ctrl;
               rdata_d = alu_out;
               rzr_d   = alu_zr;
               rng_d   = alu_ng;
            end
            state_d = StResp;
         end
         StMul: begin
            alu_x   = acc_q;
            alu_y   = x_q;
            ctrl    = CtrlAdd;
            mul_sum = y_q[0] ? alu_out : acc_q;
            acc_d   = mul_sum;
            x_d     = x_q << 1;
            y_d     = y_q >> 1;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               rdata_d = mul_sum;
               rzr_d   = (mul_sum == 16'h0000);
               rng_d   = mul_sum[15];
               state_d = StResp;
            end
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;
   assign resp_valid = (state_q == StResp);
   assign resp_id    = id_q;
   assign resp_data  = rdata_q;
   assign resp_zr    = rzr_q;
   assign resp_ng    = rng_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= 3'd0;
         x_q     <= 16'h0000;
         y_q     <= 16'h0000;
         acc_q   <= 16'h0000;
         cnt_q   <= 4'd0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         rdata_q <= 16'h0000;
         rzr_q   <= 1'b0;
         rng_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         x_q     <= x_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         last_q  <= last_d;
         rdata_q <= rdata_d;
         rzr_q   <= rzr_d;
         rng_q   <= rng_d;
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: randomized and directed bench for alu_scheduler.
// A behavioural model of the shared ALU is attached to the DUT. Expected results, grant
// order and latency come from a plain arithmetic reference, not from the DUT.
module tb_alu_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [2:0]  req0_op, req1_op;
   logic [15:0] req0_x, req0_y, req1_x, req1_y;
   logic        req0_ready, req1_ready;
   logic [15:0] alu_x, alu_y, alu_out;
   logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
   logic        resp_valid, resp_id, resp_zr, resp_ng, resp_ready;
   logic [15:0] resp_data;

   always #5 clock = ~clock;

   alu_scheduler dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_op    (req0_op),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req1_valid (req1_valid),
      .req1_op    (req1_op),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .alu_x      (alu_x),
      .alu_y      (alu_y),
      .alu_zx     (alu_zx),
      .alu_nx     (alu_nx),
      .alu_zy     (alu_zy),
      .alu_ny     (alu_ny),
      .alu_f      (alu_f),
      .alu_no     (alu_no),
      .alu_out    (alu_out),
      .alu_zr     (alu_zr),
      .alu_ng     (alu_ng),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_zr    (resp_zr),
      .resp_ng    (resp_ng),
      .resp_ready (resp_ready)
   );

   // Shared combinational ALU (zero/negate inputs, add or and, negate output).
   logic [15:0] ax, ay, ao;
   always_comb begin
      ax = alu_zx ? 16'h0000 : alu_x;
      if (alu_nx) ax = ~ax;
      ay = alu_zy ? 16'h0000 : alu_y;
      if (alu_ny) ay = ~ay;
      ao = alu_f ? (ax + ay) : (ax & ay);
      if (alu_no) ao = ~ao;
   end
   assign alu_out = ao;
   assign alu_zr  = (ao == 16'h0000);
   assign alu_ng  = ao[15];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Returns {zr, ng, data} for a command.
   function automatic logic [17:0] ref_result(input logic [2:0] op, input logic [15:0] x,
                                              input logic [15:0] y);
      logic [15:0] d;
      logic [31:0] p;
      p = 32'(x) * 32'(y);
      case (op)
         3'd0:    d = x + y;
         3'd1:    d = x - y;
         3'd2:    d = x & y;
         3'd3:    d = x | y;
         3'd4:    d = 16'h0000 - x;
         3'd5:    d = p[15:0];
         default: d = 16'h0000;
      endcase
      return {(d == 16'h0000), d[15], d};
   endfunction

   function automatic logic [5:0] ctrl_of(input logic [2:0] op);
      case (op)
         3'd0:    return 6'b000010;
         3'd1:    return 6'b010011;
         3'd3:    return 6'b010101;
         3'd4:    return 6'b001111;
         default: return 6'b000000;
      endcase
   endfunction

   function automatic logic [15:0] rnd16();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0:       return 16'(r[3:0]);
         1:       return 16'hFFFF - 16'(r[3:0]);
         default: return r[15:0];
      endcase
   endfunction

   bit          pend_v[2];
   logic [2:0]  pend_op[2];
   logic [15:0] pend_x[2], pend_y[2];
   int          ptr;

   task automatic set_cmd(input int r, input logic [2:0] op, input logic [15:0] x,
                          input logic [15:0] y);
      pend_v[r]  = 1'b1;
      pend_op[r] = op;
      pend_x[r]  = x;
      pend_y[r]  = y;
   endtask

   task automatic drive_reqs();
      req0_valid = pend_v[0];
      req0_op    = pend_op[0];
      req0_x     = pend_x[0];
      req0_y     = pend_y[0];
      req1_valid = pend_v[1];
      req1_op    = pend_op[1];
      req1_x     = pend_x[1];
      req1_y     = pend_y[1];
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_ctl"}, 32'({req0_ready, req1_ready, resp_valid, resp_id, resp_zr,
                                   resp_ng, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
                                   resp_data}), 32'h0);
      check_eq({tag, "_alu"}, {alu_x, alu_y}, 32'h0);
   endtask

   // Called just after a falling edge with the DUT idle and at least one command pending.
   task automatic run_txn(input int hold, output int gid);
      int          eg, n, lat;
      logic        eg_b;
      logic [2:0]  eop;
      logic [17:0] er;
      drive_reqs();
      #1;
      eg   = (pend_v[0] && pend_v[1]) ? 1 - ptr : (pend_v[1] ? 1 : 0);
      eg_b = (eg == 1);
      check_eq("grant_rdy0", 32'(req0_ready), 32'(eg == 0));
      check_eq("grant_rdy1", 32'(req1_ready), 32'(eg == 1));
      eop = pend_op[eg];
      er  = ref_result(eop, pend_x[eg], pend_y[eg]);
      lat = (eop == 3'd5) ? 17 : 2;
      ptr = eg;
      pend_v[eg] = 1'b0;
      gid = eg;
      @(posedge clock);
      @(negedge clock);
      drive_reqs();
      #1;
      if (eop != 3'd5)
         check_eq("exec_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}),
                  32'(ctrl_of(eop)));
      n = 1;
      while (!resp_valid && n < 40) begin
         check_eq("busy_rdy", 32'({req0_ready, req1_ready}), 32'h0);
         @(negedge clock);
         #1;
         n++;
      end
      check_eq("latency", n, lat);
      check_eq("resp", 32'({resp_valid, resp_id, resp_zr, resp_ng, resp_data}),
               32'({1'b1, eg_b, er}));
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         #1;
         check_eq("hold_resp", 32'({resp_valid, resp_id, resp_zr, resp_ng, resp_data}),
                  32'({1'b1, eg_b, er}));
         check_eq("hold_rdy", 32'({req0_ready, req1_ready}), 32'h0);
         check_eq("hold_alu", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}) |
                  32'(alu_x) | 32'(alu_y), 32'h0);
      end
      resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      resp_ready = 1'b0;
      #1;
      check_eq("resp_done", 32'(resp_valid), 32'h0);
   endtask

   task automatic flush();
      int g;
      while (pend_v[0] || pend_v[1]) run_txn(0, g);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  g;
      bit  seen;
      reset      = 1'b1;
      resp_ready = 1'b0;
      pend_v[0]  = 1'b0;
      pend_v[1]  = 1'b0;
      for (int r = 0; r < 2; r++) begin
         pend_op[r] = 3'd0;
         pend_x[r]  = 16'h0;
         pend_y[r]  = 16'h0;
      end
      ptr = 1;
      drive_reqs();
      repeat (2) @(negedge clock);
      #1;
      check_reset_outs("reset_outs");
      reset = 1'b0;
      @(negedge clock);

      // Continuous contention with ADDs: grants alternate starting with requester 0.
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < 2; r++) if (!pend_v[r]) set_cmd(r, 3'd0, rnd16(), rnd16());
         run_txn(0, g);
         check_eq("rr_alt", g, i % 2);
      end
      flush();

      set_cmd(0, 3'd0, 16'h0003, 16'h0004);  run_txn(1, g);
      set_cmd(1, 3'd1, 16'h0002, 16'h0005);  run_txn(0, g);
      set_cmd(0, 3'd2, 16'h00F0, 16'h0F00);  run_txn(0, g);
      set_cmd(1, 3'd3, 16'h1200, 16'h0034);  run_txn(0, g);
      set_cmd(0, 3'd4, 16'h0001, 16'h0000);  run_txn(0, g);
      set_cmd(0, 3'd5, 16'h0007, 16'h0006);  run_txn(0, g);
      set_cmd(1, 3'd5, 16'h0100, 16'h0100);  run_txn(0, g);
      set_cmd(0, 3'd6, 16'h1234, 16'h5678);  run_txn(0, g);
      set_cmd(1, 3'd7, 16'hFFFF, 16'h8000);  run_txn(0, g);

      // Response stall with the other requester waiting.
      set_cmd(0, 3'd3, 16'h00A5, 16'h5A00);
      set_cmd(1, 3'd0, 16'h7FFF, 16'h0001);
      run_txn(5, g);
      flush();

      // Reset in the middle of a multiply.
      set_cmd(0, 3'd5, 16'h1234, 16'h00FF);
      drive_reqs();
      @(posedge clock);
      pend_v[0] = 1'b0;
      @(negedge clock);
      drive_reqs();
      repeat (7) @(negedge clock);
      reset = 1'b1;
      #1;
      check_reset_outs("mid_reset");
      @(negedge clock);
      reset = 1'b0;
      ptr   = 1;
      seen  = 1'b0;
      repeat (20) begin
         @(negedge clock);
         #1;
         if (resp_valid) seen = 1'b1;
      end
      check_eq("no_resp_after_reset", 32'(seen), 32'h0);
      set_cmd(0, 3'd0, 16'h1111, 16'h2222);
      run_txn(0, g);

      // Randomized traffic.
      repeat (60) begin
         for (int r = 0; r < 2; r++)
            if (!pend_v[r] && $urandom_range(0, 2) != 0)
               set_cmd(r, 3'($urandom_range(0, 7)), rnd16(), rnd16());
         if (!pend_v[0] && !pend_v[1]) set_cmd(0, 3'($urandom_range(0, 7)), rnd16(), rnd16());
         run_txn($urandom_range(0, 3), g);
      end
      flush();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
